// File: rtl/reg_slice_skid.sv
// Two-entry valid/ready register slice with a skid register.
// Every output comes straight from a flop, so no input-to-output timing path exists.
module reg_slice_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  ready_q, ready_d;
    logic                  in_fire, out_fire;

    assign in_fire  = i_valid & ready_q;
    assign out_fire = (state_q != EMPTY) & i_ready;

    // ready_q is cleared by reset, so the first edge after release accepts nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = i_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = i_data;
                end else if (in_fire) begin
                    skid_d  = i_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready_q is low here, so only the reader can move the slice.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    always_comb begin
        o_valid = 1'b0;
        o_level = 2'd0;
        unique case (state_q)
            EMPTY: begin
                o_valid = 1'b0;
                o_level = 2'd0;
            end
            BUSY: begin
                o_valid = 1'b1;
                o_level = 2'd1;
            end
            FULL: begin
                o_valid = 1'b1;
                o_level = 2'd2;
            end
            default: begin
                o_valid = 1'b0;
                o_level = 2'd0;
            end
        endcase
    end

    assign o_data  = main_q;
    assign o_ready = ready_q;

endmodule
